// File: rtl/inst_fetch_bridge.sv
// inst_fetch_bridge: single-outstanding bridge from the fixed-latency fetch
// port to the SRAM-like instruction bus (req / addr_ok / data_ok). Buffers one
// response for IF, gives pre-IF a busy/stall signal, discards responses
// orphaned by a flush, and answers misaligned fetches locally with fs_adel.
module inst_fetch_bridge #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    // fetch side
    input  logic              fs_req,
    input  logic [ADDR_W-1:0] fs_addr,
    output logic              fs_busy,
    input  logic              fs_cancel,
    output logic              fs_rvalid,
    input  logic              fs_rready,
    output logic [31:0]       fs_rdata,
    output logic              fs_adel,
    // instruction bus side
    output logic              inst_req,
    output logic              inst_wr,
    output logic [1:0]        inst_size,
    output logic [ADDR_W-1:0] inst_addr,
    output logic [31:0]       inst_wdata,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [31:0]       inst_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,  // nothing in flight, no buffered response
        S_REQ  = 2'd1,  // inst_req high, waiting for addr_ok
        S_WAIT = 2'd2,  // address taken, waiting for data_ok
        S_HOLD = 2'd3   // response buffered for IF
    } state_e;

    state_e            state_q;
    logic              discard_q;   // in-flight transaction was flushed
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       rdata_q;
    logic              adel_q;

    logic accept;
    logic misalign;

    // Free only when empty, or when the buffered response leaves this cycle.
    always_comb begin
        fs_busy = !((state_q == S_IDLE) || ((state_q == S_HOLD) && fs_rready));
    end

    assign accept   = fs_req && !fs_busy;
    assign misalign = |fs_addr[1:0];

    // Main FSM: launches bus requests, tracks flushes, captures responses.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            discard_q <= 1'b0;
            addr_q    <= '0;
            rdata_q   <= '0;
            adel_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_HOLD: begin
                    // A new accept wins over draining/flushing the buffer;
                    // a request taken alongside fs_cancel is never killed.
                    if (accept) begin
                        if (misalign) begin
                            state_q <= S_HOLD;
                            rdata_q <= '0;
                            adel_q  <= 1'b1;
                        end else begin
                            addr_q    <= fs_addr;
                            discard_q <= 1'b0;
                            state_q   <= S_REQ;
                        end
                    end else if ((state_q == S_HOLD) && (fs_rready || fs_cancel)) begin
                        state_q <= S_IDLE;
                    end
                end
                S_REQ: begin
                    // The bus request is never withdrawn; a flush only marks it.
                    if (fs_cancel)    discard_q <= 1'b1;
                    if (inst_addr_ok) state_q   <= S_WAIT;
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        if (discard_q || fs_cancel) begin
                            discard_q <= 1'b0;
                            state_q   <= S_IDLE;
                        end else begin
                            rdata_q <= inst_rdata;
                            adel_q  <= 1'b0;
                            state_q <= S_HOLD;
                        end
                    end else if (fs_cancel) begin
                        discard_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign inst_req   = (state_q == S_REQ);
    assign inst_addr  = addr_q;
    assign inst_wr    = 1'b0;
    assign inst_size  = 2'b10;
    assign inst_wdata = 32'd0;

    assign fs_rvalid  = (state_q == S_HOLD);
    assign fs_rdata   = rdata_q;
    assign fs_adel    = adel_q;

endmodule

// File: doc/inst_fetch_bridge.md
# inst_fetch_bridge

Single-outstanding bridge between the fetch stage's simple instruction-SRAM port and the CPU's SRAM-like instruction bus (req/addr_ok/data_ok). It sits directly upstream of the IF stage. It turns a fixed-latency fetch request into a variable-latency bus transaction and buffers the returned word until IF accepts it. It also gives IF a busy signal for stalling pre-IF, a flush input that discards stale responses after branch/eret/exception redirects, and suppression of misaligned fetches.

## Interface
- ADDR_W, 32: fetch/bus address width; data fixed at 32 bits.
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  synchronous, active-low reset.
- fs_req  in  1  fetch request from pre-IF; held with fs_addr until accepted.
- fs_addr  in  ADDR_W  fetch address.
- fs_busy  out  1  bridge cannot accept fs_req this cycle.
- fs_cancel  in  1  flush: kill every transaction accepted before this cycle.
- fs_rvalid  out  1  fs_rdata/fs_adel valid.
- fs_rready  in  1  IF consumes the buffered response this cycle.
- fs_rdata  out  32  fetched instruction; 0 for misaligned fetches.
- fs_adel  out  1  response belongs to a misaligned (addr[1:0]!=0) fetch.
- inst_req  out  1  bus request.
- inst_wr  out  1  constant 0.
- inst_size  out  2  constant 2'b10 (word).
- inst_addr  out  ADDR_W  bus address, registered.
- inst_wdata  out  32  constant 0.
- inst_addr_ok  in  1  bus accepts the address this cycle.
- inst_data_ok  in  1  bus returns read data this cycle.
- inst_rdata  in  32  bus read data, valid with inst_data_ok.

## Operation
- States: IDLE, REQ (inst_req=1, waiting addr_ok), WAIT (waiting data_ok), HOLD (response buffered).
- Accept = fs_req && !fs_busy. fs_busy = !(IDLE || (HOLD && fs_rready)).
- IDLE/HOLD-with-fs_rready plus accept, aligned address: latch inst_addr=fs_addr, go REQ.
- Same condition, misaligned address: no bus access. Go HOLD with fs_rdata=0, fs_adel=1.
- HOLD && fs_rready && no accept: go IDLE. HOLD && !fs_rready: stay, outputs stable.
- REQ: inst_req held high, inst_addr stable until inst_addr_ok. On addr_ok go WAIT. The request is never withdrawn, including under cancel.
- WAIT: on inst_data_ok, if discard=0 capture inst_rdata into fs_rdata, fs_adel=0, go HOLD. If discard=1, drop the data, clear discard, go IDLE.
- fs_cancel, applied to state at cycle start:
  - IDLE: no effect.
  - REQ or WAIT: set discard=1.
  - HOLD: drop the buffer, fs_rvalid low next cycle, go IDLE unless an accept occurs.
- A request accepted in the same cycle as fs_cancel survives; cancel applies only to older transactions.
- inst_data_ok in IDLE, REQ or HOLD is ignored; no state change.
- fs_rvalid = (state==HOLD), registered.

## Timing
- Reset (resetn=0 at an edge): state IDLE, discard 0, inst_req 0, inst_addr 0, fs_rvalid 0, fs_rdata 0, fs_adel 0, fs_busy 0. Takes effect mid-transaction; any in-flight bus response after reset is ignored.
- Best-case latency: accept at T, inst_req high T+1, addr_ok T+1, data_ok T+2, fs_rvalid T+3.
- Misaligned latency: accept at T, fs_rvalid/fs_adel at T+1, bus untouched.
- Back-to-back throughput: one fetch per 3 cycles at zero bus wait. Accepting in the same cycle as HOLD consumption gives no bubble on the request side.
- Cancel during REQ/WAIT keeps fs_busy high until the killed data_ok arrives. The requester keeps the redirect address on fs_req/fs_addr until accepted.
- Outputs inst_wr/inst_size/inst_wdata are constant from reset.

## Test plan
- Aligned fetch 0xbfc00000, addr_ok same cycle as req, data_ok next cycle with 0x24080001 -> fs_rvalid at T+3, fs_rdata=0x24080001, fs_adel=0, fs_busy high T+1..T+2.
- addr_ok withheld 4 cycles -> inst_req and inst_addr=0xbfc00004 stable all 4 cycles; one fetch completes with correct data.
- fs_cancel in WAIT while fs_req=1 at 0xbfc00380; data_ok returns 0xdeadbeef -> no fs_rvalid for 0xdeadbeef. Next cycle 0xbfc00380 is accepted and its data is returned.
- Misaligned fetch 0xbfc00002 -> no inst_req; next cycle fs_rvalid=1, fs_adel=1, fs_rdata=0.
- HOLD with fs_rready=0 for 3 cycles, then fs_rready=1 with new fs_req -> data held stable; new inst_req next cycle; fs_cancel in HOLD drops the buffer.
- resetn low while in WAIT, then data_ok arrives -> all outputs return to reset values; stray data_ok ignored, fs_rvalid stays 0.
